mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file read ports: its operands are the two register read values (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. HI/LO are exposed for MFHI/MFLO, which return through the register file write port. It asserts `busy` so the pipeline control stalls dependent instructions.

## Interface
- `WIDTH`, 32: operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- `clk` input 1: the only clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: operation request, sampled on the rising edge of `clk`.
- `op` input 3: operation select.
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 11x reserved; `start` with a reserved op is a no-op.
- `rs_data` input WIDTH: multiplicand or dividend; source for MTHI/MTLO.
- `rt_data` input WIDTH: multiplier or divisor.
- `cancel` input 1: abort the in-flight operation (pipeline flush).
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse when HI/LO have just been updated by mult/div.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States:
  - IDLE
  - RUN (iteration counter 0..WIDTH-1)
  - FIN
- IDLE, `start` with MULT/MULTU/DIV/DIVU, `cancel`=0:
  - Latch the operand magnitudes. Signed ops use two's-complement absolute values; unsigned ops use raw values.
  - Latch the result-sign flags and the op type.
  - Go to RUN with counter=0.
- IDLE, `start` with MTHI/MTLO, `cancel`=0: write `rs_data` to `hi` (MTHI) or `lo` (MTLO) on that edge. No busy, no done.
- RUN:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - After counter=WIDTH-1, go to FIN.
- FIN: apply sign fixup, write `hi`/`lo`, go to IDLE.
- Sign and result rules:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product. MULT negates the product when exactly one operand is negative.
  - DIV/DIVU: lo = quotient, hi = remainder. DIV negates the quotient when the operand signs differ; the remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
  - Divide by zero (both signednesses) runs the full latency and gives lo=0xFFFFFFFF, hi=rs_data as latched. No exception.
- While `busy`=1:
  - `start` is ignored for every op, including MTHI/MTLO. No queuing; upstream must stall.
  - Operand inputs are don't-care.
- `cancel`:
  - In RUN or FIN: return to IDLE on that edge. `hi`/`lo` unchanged, no `done`.
  - In IDLE: suppresses a coincident `start` (nothing is accepted).
- Reset, asynchronous, at any time including mid-operation: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, internal accumulators cleared.

## Timing
- Edge E0 accepts `start`. `busy`=1 from after E0 until after edge E0+WIDTH+1.
- RUN spans edges E1..E_WIDTH. FIN is the cycle after E_WIDTH.
- Edge E_WIDTH+1 writes `hi`/`lo`, drops `busy`, and sets `done`=1 for exactly one cycle.
- Total latency is WIDTH+1 edges (33 for WIDTH=32), independent of operand values.
- A new `start` is accepted on the edge where `done` is high, so back-to-back ops run with zero bubble.
- MTHI/MTLO are visible on `hi`/`lo` in the cycle after the accepting edge.
- `busy`, `done`, `hi`, `lo` are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=5: at the 33rd edge hi=0xFFFFFFFF, lo=0xFFFFFFF1. `done` is high exactly one cycle; `busy` is high 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001. Immediately after, on the `done` edge, start DIVU rs=100, rt=7: lo=14, hi=2, with no idle gap.
- DIV rs=0xFFFFFFF9 (-7), rt=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0. DIVU 5/0 gives lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 while idle sets hi=0x1234 on the next cycle. MTLO 0xAAAA issued during a running MULT is ignored, so lo ends as the product.
- Start MULT, assert `cancel` at cycle 10: `busy` drops next edge, hi/lo keep their prior values, no `done`. Then `start` plus `cancel` together while idle: nothing is accepted.
- Pulse `rst_n` low mid-DIV at cycle 20, asynchronously between edges: `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a fresh MULT 6×7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the register-file read stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO registers.
// One result bit per cycle, fixed WIDTH+1 edge latency, cancellable by pipeline flush.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] raw_a;
    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    logic             start_ok, is_md, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             load, iterate, write_res, mt_hi, mt_lo;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [AW-1:0]    mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    // Request decode and operand magnitudes
    assign start_ok = bus.start & ~bus.cancel;
    assign is_md    = ~bus.op[2];
    assign op_div   = bus.op[1];
    assign a_neg    = ~bus.op[0] & bus.rs_data[WIDTH-1];
    assign b_neg    = ~bus.op[0] & bus.rt_data[WIDTH-1];
    assign mag_a    = a_neg ? WIDTH'(-bus.rs_data) : bus.rs_data;
    assign mag_b    = b_neg ? WIDTH'(-bus.rt_data) : bus.rt_data;

    // One iteration step: multiplier bit consumed from acc LSB, quotient bit shifted in at LSB
    assign mul_sum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = acc[AW-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // Sign fixup; divide-by-zero returns all-ones quotient and the raw dividend
    assign prod   = neg_q ? AW'(-acc) : acc;
    assign quo    = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem    = neg_r ? WIDTH'(-acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];
    assign res_hi = !is_div ? prod[AW-1:WIDTH] : (div_zero ? raw_a : rem);
    assign res_lo = !is_div ? prod[WIDTH-1:0]  : (div_zero ? '1 : quo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && is_md) state_nxt = RUN;
            RUN:     if (bus.cancel) state_nxt = IDLE;
                     else if (count == CW'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        iterate   = 1'b0;
        write_res = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            IDLE: if (start_ok) begin
                load  = is_md;
                mt_hi = (bus.op == 3'b100);
                mt_lo = (bus.op == 3'b101);
            end
            RUN:     iterate   = ~bus.cancel;
            FIN:     write_res = ~bus.cancel;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= write_res;
            if (load) begin
                acc      <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                opnd     <= op_div ? mag_b : mag_a;
                raw_a    <= bus.rs_data;
                is_div   <= op_div;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (bus.rt_data == '0);
                count    <= '0;
            end else if (iterate) begin
                acc   <= is_div ? div_nxt : mul_nxt;
                count <= count + CW'(1);
            end
            if (write_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            if (mt_hi) hi_q <= bus.rs_data;
            if (mt_lo) lo_q <= bus.rs_data;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed test of mult_div_unit: products, quotients, sign rules, latency, cancel and async reset.
module tb_mult_div_unit;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   lat;
    int   bcyc;
    int   seen;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        tick();
        bus.start   = 1'b0;
    endtask

    // Counts edges after the accepting edge until done, and cycles with busy high
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = bus.busy ? 1 : 0;
        while (!bus.done && l < 100) begin
            tick();
            l++;
            if (bus.busy) b++;
        end
    endtask

    task automatic count_done(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done) s++;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.cancel  = 1'b0;
        #12;
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_hi", 64'(bus.hi), 64'h0);
        check("rst_lo", 64'(bus.lo), 64'h0);
        rst_n = 1'b1;
        tick();

        // MULT -3 * 5
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bcyc);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(bcyc), 64'd33);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        check("mult_busy_at_done", 64'(bus.busy), 64'h0);
        tick();
        check("mult_done_one_cycle", 64'(bus.done), 64'h0);

        // MULTU max*max, then DIVU back-to-back on the done edge
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("multu_done", 64'(bus.done), 64'h1);
        check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0001);
        issue(3'b011, 32'd100, 32'd7);
        check("divu_b2b_busy", 64'(bus.busy), 64'h1);
        wait_done(lat, bcyc);
        check("divu_latency", 64'(lat), 64'd33);
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);

        // Signed divide and corner cases
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcyc);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(bus.hi), 64'h0);
        issue(3'b011, 32'd5, 32'd0);
        wait_done(lat, bcyc);
        check("divu0_latency", 64'(lat), 64'd33);
        check("divu0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("divu0_hi", 64'(bus.hi), 64'd5);

        // MTHI while idle, MTLO ignored while busy
        issue(3'b100, 32'h0000_1234, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_busy", 64'(bus.busy), 64'h0);
        check("mthi_done", 64'(bus.done), 64'h0);
        issue(3'b000, 32'h10, 32'h20);
        bus.start   = 1'b1;
        bus.op      = 3'b101;
        bus.rs_data = 32'h0000_AAAA;
        tick();
        tick();
        bus.start = 1'b0;
        check("mtlo_busy_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        wait_done(lat, bcyc);
        check("mtlo_ignored_lo", 64'(bus.lo), 64'h200);
        check("mtlo_ignored_hi", 64'(bus.hi), 64'h0);

        // Cancel mid-multiply
        issue(3'b000, 32'd6, 32'd7);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'h0);
        check("cancel_done", 64'(bus.done), 64'h0);
        count_done(40, seen);
        check("cancel_no_done", 64'(seen), 64'h0);
        check("cancel_hi", 64'(bus.hi), 64'h0);
        check("cancel_lo", 64'(bus.lo), 64'h200);

        // start with cancel while idle is dropped
        bus.cancel = 1'b1;
        issue(3'b000, 32'd6, 32'd7);
        check("start_cancel_busy", 64'(bus.busy), 64'h0);
        issue(3'b100, 32'h0000_DEAD, 32'd0);
        bus.cancel = 1'b0;
        check("mthi_cancel_hi", 64'(bus.hi), 64'h0);
        count_done(40, seen);
        check("start_cancel_no_done", 64'(seen), 64'h0);
        check("start_cancel_lo", 64'(bus.lo), 64'h200);

        // Asynchronous reset mid-divide
        issue(3'b100, 32'h0000_5555, 32'd0);
        issue(3'b010, 32'd100, 32'd7);
        repeat (19) tick();
        check("pre_reset_busy", 64'(bus.busy), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_busy", 64'(bus.busy), 64'h0);
        check("areset_done", 64'(bus.done), 64'h0);
        check("areset_hi", 64'(bus.hi), 64'h0);
        check("areset_lo", 64'(bus.lo), 64'h0);
        #2;
        rst_n = 1'b1;
        tick();
        issue(3'b000, 32'd6, 32'd7);
        wait_done(lat, bcyc);
        check("post_reset_latency", 64'(lat), 64'd33);
        check("post_reset_lo", 64'(bus.lo), 64'd42);
        check("post_reset_hi", 64'(bus.hi), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
